// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter: mode encoding and the
// round-robin pointer wrap-increment used for any source count.
package arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // Next pointer after granting idx; wraps at n, so non-power-of-two counts work.
   function automatic int unsigned ptr_wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Masked priority encoder: lowest set request at or above start, falling back
// to the lowest set request overall when nothing at or above start is pending.
module prio_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [N-1:0] mask;
   logic [N-1:0] masked;
   logic [N-1:0] pick_src;
   logic         found;

   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(N); i++) begin
         mask[i] = (i >= int'(start));
      end
      masked   = req & mask;
      pick_src = (|masked) ? masked : req;

      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && pick_src[i]) begin
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
            found     = 1'b1;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with valid/ready output slot; fixed or round-robin
// priority chosen per cycle by rr_en.
module rr_priority_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rr_en,
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [DATA_WIDTH-1:0] data_in [NUM_INPUTS],
   output logic [NUM_INPUTS-1:0] ack,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [IDX_W-1:0]      grant
);

   localparam logic [IDX_W-1:0] StartZero = '0;

   arb_mode_e mode;

   logic [NUM_INPUTS-1:0] fix_oh, rr_oh, win_oh;
   logic [IDX_W-1:0]      fix_idx, rr_idx, win_idx;
   logic                  fix_any, rr_any, win_any;
   logic                  load;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

   prio_pick #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_pick_fixed (
      .req    (req),
      .start  (StartZero),
      .onehot (fix_oh),
      .idx    (fix_idx),
      .any    (fix_any)
   );

   prio_pick #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_pick_rr (
      .req    (req),
      .start  (rr_ptr_q),
      .onehot (rr_oh),
      .idx    (rr_idx),
      .any    (rr_any)
   );

   always_comb begin
      mode = arb_mode_e'(rr_en);
      unique case (mode)
         ARB_RR: begin
            win_oh  = rr_oh;
            win_idx = rr_idx;
            win_any = rr_any;
         end
         default: begin
            win_oh  = fix_oh;
            win_idx = fix_idx;
            win_any = fix_any;
         end
      endcase

      // Reset suppresses the capture so no ack escapes in the reset cycle.
      load = win_any && (!out_valid_q || out_ready) && !rst;
      ack  = load ? win_oh : '0;

      out_valid_d = out_valid_q;
      data_out_d  = data_out_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = 1'b1;
         data_out_d  = data_in[win_idx];
         grant_d     = win_idx;
         rr_ptr_d    = IDX_W'(ptr_wrap_inc(32'(win_idx), NUM_INPUTS));
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign grant     = grant_q;

endmodule
